pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//   Parametrised pipeline-stage register that replaces fixed write-enable stage registers.
//   Carries one DATA_W payload per beat (e.g. {PC+4, instruction}) with a valid/ready handshake.
//   A 2-entry skid buffer gives full throughput, and in_ready is driven straight from a flop.
//   Sits between any two pipeline stages (IF/ID, ID/EX, ...) and supports a synchronous flush
//   for branch/exception squash.
// PARAMETERS
//   DATA_W   64  payload width in bits
//   RST_VAL  0   value of out_data after reset; zero-extended/truncated to DATA_W
//   CNT_W    32  stall counter width; used only with PIPE_STALL_CNT_EN
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   flush      in   1       sync squash: drop all held beats this cycle
//   in_valid   in   1       upstream beat valid
//   in_ready   out  1       stage can accept a beat (registered)
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       downstream beat valid
//   out_ready  in   1       downstream accepts beat
//   out_data   out  DATA_W  downstream payload
//   occupancy  out  2       beats held: 0, 1 or 2
//   stall_cnt  out  CNT_W   present only with PIPE_STALL_CNT_EN
// BEHAVIOUR
//   Storage: main reg (drives out_data) and skid reg.
//     State EMPTY=0, ONE=1, FULL=2; occupancy = state.
//   out_valid = (state != EMPTY); in_ready = (state != FULL); both come directly from flops.
//   Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
//   EMPTY: in_xfer -> main<=in_data, go ONE.
//   ONE:
//     - in_xfer & out_xfer -> main<=in_data, stay ONE.
//     - in_xfer & !out_xfer -> skid<=in_data, go FULL.
//     - !in_xfer & out_xfer -> go EMPTY.
//     - Otherwise hold.
//   FULL:
//     - in_ready=0, so in_data is ignored.
//     - out_xfer -> main<=skid, go ONE.
//     - Otherwise hold.
//   Latency: a beat accepted in cycle N appears on out_* in cycle N+1.
//   Throughput: 1 beat/cycle while out_ready=1.
//   Ordering: strict FIFO; no beat is duplicated or lost except by flush.
//   Stability: while out_valid & !out_ready, out_data must not change.
//   flush=1 has highest priority:
//     - Next state is EMPTY and any in_xfer that cycle is discarded.
//     - Data regs keep their contents; they are don't-care while invalid.
//   Async reset (rst_n=0), mid-operation included:
//     - state=EMPTY, out_valid=0, in_ready=1, occupancy=0.
//     - out_data=RST_VAL, skid=0, stall_cnt=0.
//   Outputs settle during reset without a clock. Deassertion is synchronised externally.
//   Upstream may drop in_valid at any time; this block adds no hold requirement on upstream.
// CONFIGURATION
//   PIPE_STALL_CNT_EN defined:
//     - Adds port stall_cnt.
//     - Increments on every cycle with out_valid & !out_ready & !flush.
//     - Saturates at 2^CNT_W-1 (no wrap). Cleared only by reset; flush does not clear it.
//   PIPE_STALL_CNT_EN undefined: port stall_cnt and its logic are absent; all other behaviour identical.
// TESTING
//   1. Reset with rst_n=0 and no clock edge
//        -> out_valid=0, in_ready=1, occupancy=0, out_data=RST_VAL.
//   2. Stream 0xA1..0xA8, one per cycle, out_ready=1
//        -> same order out, first at +1 cycle, 8 beats in 8 consecutive cycles, occupancy=1 throughout.
//   3. out_ready=0 while sending 0xB1, 0xB2, 0xB3
//        -> 0xB1 and 0xB2 held, occupancy=2, in_ready=0, 0xB3 held off upstream.
//      Then out_ready=1
//        -> 0xB1, 0xB2, 0xB3 out in order, no loss or duplication.
//   4. occupancy=2 with flush=1 and in_valid=1 (0xC1) in the same cycle
//        -> next cycle occupancy=0, out_valid=0, in_ready=1, and 0xC1 is never output.
//   5. rst_n=0 asserted mid-stream while FULL -> immediate EMPTY.
//      After release, send 0xD1 -> 0xD1 out after 1 cycle.
//   6. PIPE_STALL_CNT_EN, CNT_W=4, out_valid=1, out_ready=0 for 20 cycles
//        -> stall_cnt=15 (saturated), and it survives a flush.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a 2-entry skid buffer, registered in_ready and sync flush.
// Optional saturating stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int unsigned       CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign occupancy = state;

  // out_data is the main register; out_valid/in_ready are kept as their own flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= RST_VAL;
      skid      <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_data  <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (in_xfer) begin
            skid     <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_data <= skid;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Saturating count of cycles where a valid beat is back-pressured; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (DATA_W=16, RST_VAL=16'h5A5A, CNT_W=4).
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] RST_V = 16'h5A5A;

  logic              clk;
  logic              clk_en;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [3:0]        stall_cnt;
`endif

  int tests_run;
  int tests_failed;

  pipe_skid_reg #(.DATA_W(DATA_W), .RST_VAL(RST_V), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Advance one rising edge; outputs are then sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    tests_run++; if (out_data !== RST_V) begin tests_failed++; $display("FAIL reset_out_data: got %h expected %h", out_data, RST_V); end
    clk_en = 1'b1;
    #12 rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(16'hA1 + i);
      step();
      tests_run++; if (out_valid !== 1'b1 || out_data !== DATA_W'(16'hA1 + i)) begin tests_failed++; $display("FAIL stream_beat%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 16'hA1 + i); end
      tests_run++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_occ%0d: got occ=%0d rdy=%b expected occ=1 rdy=1", i, occupancy, in_ready); end
    end
    in_valid = 1'b0;
    step();
    tests_run++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin tests_failed++; $display("FAIL stream_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hB1;
    step();
    tests_run++; if (out_data !== 16'hB1 || occupancy !== 2'd1) begin tests_failed++; $display("FAIL bp_first: got d=%h occ=%0d expected d=00b1 occ=1", out_data, occupancy); end
    in_data = 16'hB2;
    step();
    tests_run++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'hB1) begin tests_failed++; $display("FAIL bp_full: got occ=%0d rdy=%b d=%h expected occ=2 rdy=0 d=00b1", occupancy, in_ready, out_data); end
    in_data = 16'hB3;
    step();
    tests_run++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'hB1) begin tests_failed++; $display("FAIL bp_hold: got occ=%0d rdy=%b d=%h expected occ=2 rdy=0 d=00b1", occupancy, in_ready, out_data); end
    out_ready = 1'b1;
    step();
    tests_run++; if (out_data !== 16'hB2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_b2: got d=%h occ=%0d rdy=%b expected d=00b2 occ=1 rdy=1", out_data, occupancy, in_ready); end
    step();
    tests_run++; if (out_data !== 16'hB3 || out_valid !== 1'b1 || occupancy !== 2'd1) begin tests_failed++; $display("FAIL bp_release_b3: got d=%h v=%b occ=%0d expected d=00b3 v=1 occ=1", out_data, out_valid, occupancy); end
    in_valid = 1'b0;
    step();
    tests_run++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin tests_failed++; $display("FAIL bp_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hE1;
    step();
    in_data = 16'hE2;
    step();
    tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL flush_prefill: got occ=%0d expected 2", occupancy); end
    flush   = 1'b1;
    in_data = 16'hC1;
    step();
    tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_empty: got occ=%0d v=%b rdy=%b expected occ=0 v=0 rdy=1", occupancy, out_valid, in_ready); end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_c1_%0d: got v=%b d=%h expected v=0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hF1;
    step();
    in_data = 16'hF2;
    step();
    tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL areset_prefill: got occ=%0d expected 2", occupancy); end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL areset_state: got occ=%0d v=%b rdy=%b expected occ=0 v=0 rdy=1", occupancy, out_valid, in_ready); end
    tests_run++; if (out_data !== RST_V) begin tests_failed++; $display("FAIL areset_data: got %h expected %h", out_data, RST_V); end
    #1 rst_n = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hD1;
    out_ready = 1'b1;
    step();
    tests_run++; if (out_valid !== 1'b1 || out_data !== 16'hD1) begin tests_failed++; $display("FAIL areset_d1: got v=%b d=%h expected v=1 d=00d1", out_valid, out_data); end
    in_valid = 1'b0;
    step();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_drain: got v=%b expected 0", out_valid); end
  endtask

`ifdef PIPE_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tests_run++; if (stall_cnt !== 4'd0) begin tests_failed++; $display("FAIL stall_reset: got %0d expected 0", stall_cnt); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0077;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    tests_run++; if (stall_cnt !== 4'd5) begin tests_failed++; $display("FAIL stall_count5: got %0d expected 5", stall_cnt); end
    repeat (15) step();
    tests_run++; if (stall_cnt !== 4'd15) begin tests_failed++; $display("FAIL stall_saturate: got %0d expected 15", stall_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests_run++; if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_after_flush: got cnt=%0d v=%b expected cnt=15 v=0", stall_cnt, out_valid); end
    out_ready = 1'b1;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clk       = 1'b0;
    clk_en    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef PIPE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
